// File: rtl/ctrl_pkg.sv
// Shared types and constants for the multi-cycle control sequencer.
// The ALU-op codes are 3 bits wide and are zero-extended to the ALUOp port width at the top level.
package ctrl_pkg;

  typedef enum logic [1:0] {
    MATH   = 2'b00,
    COND   = 2'b01,
    ASSIGN = 2'b10,
    VALUES = 2'b11
  } type_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    DONE   = 3'd5
  } state_e;

  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_PASS  = 3'b111;
  localparam logic [2:0] SUB_LOAD  = 3'b000;
  localparam logic [2:0] SUB_STORE = 3'b001;

  // Controls latched at DECODE and held for the rest of the instruction.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       branch;
    logic       jump;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
  } ctrl_s;

  function automatic logic cond_taken(input logic [1:0] cond, input logic zero, input logic neg);
    logic taken;
    case (cond)
      2'b00:   taken = zero;
      2'b01:   taken = !zero;
      2'b10:   taken = neg;
      default: taken = !neg;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: maps an instruction word to the held
// control set plus memory/halt classification and the branch condition code.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int IW = 9
) (
  input  logic [IW-1:0] i_instr,
  output ctrl_s         o_ctrl,
  output logic          o_is_mem,
  output logic          o_is_halt,
  output logic [1:0]    o_cond
);

  type_e      w_type;
  logic [2:0] w_sub_op;

  assign w_type   = type_e'(i_instr[IW-1:IW-2]);
  assign w_sub_op = i_instr[IW-3:IW-5];

  always_comb begin
    o_ctrl    = '0;
    o_is_mem  = 1'b0;
    o_is_halt = &i_instr;
    o_cond    = i_instr[IW-3:IW-4];
    case (w_type)
      MATH: begin
        o_ctrl.alu_op    = w_sub_op;
        o_ctrl.reg_write = 1'b1;
      end
      COND: begin
        o_ctrl.alu_op = ALU_SUB;
        o_ctrl.branch = 1'b1;
      end
      ASSIGN: begin
        if (w_sub_op == SUB_LOAD) begin
          o_ctrl.mem_to_reg = 1'b1;
          o_ctrl.reg_write  = 1'b1;
          o_is_mem          = 1'b1;
        end else if (w_sub_op == SUB_STORE) begin
          o_ctrl.mem_write = 1'b1;
          o_is_mem         = 1'b1;
        end else begin
          o_ctrl.alu_op    = ALU_PASS;
          o_ctrl.reg_write = 1'b1;
        end
      end
      default: begin
        // VALUES: the bit below the type field selects jmp over mov.
        if (i_instr[IW-3]) begin
          o_ctrl.branch = 1'b1;
          o_ctrl.jump   = 1'b1;
        end else begin
          o_ctrl.alu_src   = 1'b1;
          o_ctrl.alu_op    = ALU_PASS;
          o_ctrl.reg_write = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM phases, branch resolution,
// memory wait states, stall handling, halt, and a saturating retired-instruction counter.
module ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int IW      = 9,
  parameter int OPW     = 3,
  parameter int MEM_LAT = 2,
  parameter int CNTW    = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic            Stall,
  input  logic [IW-1:0]   Instr,
  input  logic            Zero,
  input  logic            Neg,
  output logic            IRWrite,
  output logic            PCWrite,
  output logic            PCSrc,
  output logic            RegDst,
  output logic            Branch,
  output logic            MemtoReg,
  output logic            MemWrite,
  output logic            ALUSrc,
  output logic            RegWrite,
  output logic [OPW-1:0]  ALUOp,
  output logic            Done,
  output logic [CNTW-1:0] InstrCnt
);

  localparam int              WCW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(MEM_LAT - 1);

  state_e          r_state, w_state_next;
  logic [WCW-1:0]  r_wait, w_wait_next;
  ctrl_s           r_ctrl, w_ctrl_next;
  logic [1:0]      r_cond, w_cond_next;
  logic            r_is_mem, w_is_mem_next;
  logic [CNTW-1:0] r_cnt, w_cnt_next;

  ctrl_s      w_dec_ctrl;
  logic       w_dec_is_mem;
  logic       w_dec_is_halt;
  logic [1:0] w_dec_cond;

  logic w_ir, w_pcwrite, w_pcsrc, w_regwrite, w_memwrite;
  logic w_strobe_en;

  ctrl_decode #(
    .IW(IW)
  ) u_decode (
    .i_instr   (Instr),
    .o_ctrl    (w_dec_ctrl),
    .o_is_mem  (w_dec_is_mem),
    .o_is_halt (w_dec_is_halt),
    .o_cond    (w_dec_cond)
  );

  // A stalled or resetting cycle must never emit a strobe.
  assign w_strobe_en = !Stall && !Reset;

  always_comb begin
    w_state_next  = r_state;
    w_wait_next   = r_wait;
    w_ctrl_next   = r_ctrl;
    w_cond_next   = r_cond;
    w_is_mem_next = r_is_mem;
    w_ir          = 1'b0;
    w_pcwrite     = 1'b0;
    w_pcsrc       = 1'b0;
    w_regwrite    = 1'b0;
    w_memwrite    = 1'b0;

    case (r_state)
      IDLE, DONE: begin
        if (Start) w_state_next = FETCH;
      end
      FETCH: begin
        w_ir         = 1'b1;
        w_state_next = DECODE;
      end
      DECODE: begin
        if (w_dec_is_halt) begin
          w_ctrl_next   = '0;
          w_is_mem_next = 1'b0;
          w_state_next  = DONE;
        end else begin
          w_ctrl_next   = w_dec_ctrl;
          w_cond_next   = w_dec_cond;
          w_is_mem_next = w_dec_is_mem;
          w_state_next  = EXEC;
        end
      end
      EXEC: begin
        if (r_is_mem) begin
          w_wait_next  = '0;
          w_state_next = MEM;
        end else begin
          w_pcwrite    = 1'b1;
          w_regwrite   = r_ctrl.reg_write;
          w_pcsrc      = r_ctrl.branch && (r_ctrl.jump || cond_taken(r_cond, Zero, Neg));
          w_state_next = FETCH;
        end
      end
      MEM: begin
        w_memwrite = r_ctrl.mem_write && (r_wait == '0);
        if (r_wait == WAIT_LAST) begin
          w_pcwrite    = 1'b1;
          w_regwrite   = r_ctrl.reg_write;
          w_state_next = FETCH;
        end else begin
          w_wait_next = r_wait + 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // Stall freezes every piece of state; strobes are masked below.
    if (Stall) begin
      w_state_next  = r_state;
      w_wait_next   = r_wait;
      w_ctrl_next   = r_ctrl;
      w_cond_next   = r_cond;
      w_is_mem_next = r_is_mem;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_pcwrite && w_strobe_en && !(&r_cnt)) w_cnt_next = r_cnt + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_wait   <= '0;
      r_ctrl   <= '0;
      r_cond   <= '0;
      r_is_mem <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_next;
      r_wait   <= w_wait_next;
      r_ctrl   <= w_ctrl_next;
      r_cond   <= w_cond_next;
      r_is_mem <= w_is_mem_next;
      r_cnt    <= w_cnt_next;
    end
  end

  assign IRWrite  = w_ir && w_strobe_en;
  assign PCWrite  = w_pcwrite && w_strobe_en;
  assign PCSrc    = w_pcsrc && w_strobe_en;
  assign RegWrite = w_regwrite && w_strobe_en;
  assign MemWrite = w_memwrite && w_strobe_en;
  assign RegDst   = 1'b0;
  assign Branch   = r_ctrl.branch;
  assign MemtoReg = r_ctrl.mem_to_reg;
  assign ALUSrc   = r_ctrl.alu_src;
  assign ALUOp    = OPW'(r_ctrl.alu_op);
  assign Done     = (r_state == DONE);
  assign InstrCnt = r_cnt;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed and random instructions checked
// cycle by cycle against a per-instruction timing model derived from the instruction rules.
module tb_ctrl_fsm;

  localparam int IW      = 9;
  localparam int OPW     = 3;
  localparam int MEM_LAT = 2;
  localparam int CNTW    = 4;
  localparam int CNT_MAX = (1 << CNTW) - 1;

  logic            Clk = 1'b0;
  logic            Reset = 1'b1;
  logic            Start = 1'b0;
  logic            Stall = 1'b0;
  logic [IW-1:0]   Instr = '0;
  logic            Zero = 1'b0;
  logic            Neg = 1'b0;
  logic            IRWrite, PCWrite, PCSrc, RegDst, Branch, MemtoReg;
  logic            MemWrite, ALUSrc, RegWrite, Done;
  logic [OPW-1:0]  ALUOp;
  logic [CNTW-1:0] InstrCnt;

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt    = 0;
  int n_cyc    = 0;

  always #5 Clk = ~Clk;

  ctrl_fsm #(
    .IW(IW), .OPW(OPW), .MEM_LAT(MEM_LAT), .CNTW(CNTW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stall(Stall), .Instr(Instr),
    .Zero(Zero), .Neg(Neg), .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc),
    .RegDst(RegDst), .Branch(Branch), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .ALUOp(ALUOp), .Done(Done), .InstrCnt(InstrCnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_strobes_zero(input string tag);
    chk({tag, "_ir"}, 32'(IRWrite), 32'd0);
    chk({tag, "_pcw"}, 32'(PCWrite), 32'd0);
    chk({tag, "_rw"}, 32'(RegWrite), 32'd0);
    chk({tag, "_mw"}, 32'(MemWrite), 32'd0);
  endtask

  // Runs one instruction from its FETCH cycle; expectations come from the instruction rules.
  task automatic run_instr(input logic [IW-1:0] ins, input logic z, input logic n,
                           input int stall_at, input int stall_n,
                           input bit rnd_stall, input bit rnd_start);
    int typ, sub, cnd, k, lat, stalls;
    bit halt, load, store, regw, br, taken, alusrc, m2r, st;
    bit e_ir, e_pcw, e_rw, e_mw;
    int alu;
    typ  = int'(ins) >> (IW - 2);
    sub  = (int'(ins) >> (IW - 5)) & 7;
    cnd  = (int'(ins) >> (IW - 4)) & 3;
    halt = (int'(ins) == (1 << IW) - 1);
    load = 0; store = 0; regw = 0; br = 0; taken = 0; alusrc = 0; m2r = 0; alu = 0;
    if (typ == 0) begin
      alu = sub; regw = 1;
    end else if (typ == 1) begin
      alu = 1; br = 1;
      taken = (cnd == 0) ? z : (cnd == 1) ? !z : (cnd == 2) ? n : !n;
    end else if (typ == 2) begin
      if (sub == 0) begin load = 1; m2r = 1; regw = 1; end
      else if (sub == 1) store = 1;
      else begin alu = 7; regw = 1; end
    end else if (((int'(ins) >> (IW - 3)) & 1) == 0) begin
      alusrc = 1; alu = 7; regw = 1;
    end else begin
      br = 1; taken = 1;
    end
    lat = halt ? 2 : (load || store) ? 3 + MEM_LAT : 3;

    Instr = ins; Zero = z; Neg = n;
    k = 1; stalls = 0; n_cyc = 0;
    while (k <= lat && n_cyc < 64) begin
      if (k == stall_at && stalls < stall_n) begin
        st = 1; stalls++;
      end else begin
        st = rnd_stall && ($urandom_range(0, 3) == 0);
      end
      Stall = st;
      Start = rnd_start ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge Clk);
      e_ir  = !st && k == 1;
      e_pcw = !st && !halt && k == lat;
      e_rw  = e_pcw && regw;
      e_mw  = !st && store && k == 4;
      chk("irwrite", 32'(IRWrite), 32'(e_ir));
      chk("pcwrite", 32'(PCWrite), 32'(e_pcw));
      chk("pcsrc", 32'(PCSrc), 32'(e_pcw && taken));
      chk("regwrite", 32'(RegWrite), 32'(e_rw));
      chk("memwrite", 32'(MemWrite), 32'(e_mw));
      chk("regdst", 32'(RegDst), 32'd0);
      chk("done_low", 32'(Done), 32'd0);
      chk("instrcnt", 32'(InstrCnt), 32'(m_cnt));
      if (k >= 3) begin
        chk("branch", 32'(Branch), 32'(br));
        chk("memtoreg", 32'(MemtoReg), 32'(m2r));
        chk("alusrc", 32'(ALUSrc), 32'(alusrc));
        if (!(load || store)) chk("aluop", 32'(ALUOp), 32'(alu));
      end
      tick();
      n_cyc++;
      if (!st) begin
        if (k == lat && !halt && m_cnt < CNT_MAX) m_cnt++;
        k++;
      end
    end
    chk("cycle_budget", 32'(k), 32'(lat + 1));
    Stall = 0; Start = 0;
  endtask

  // Sits in DONE, checks a stalled Start is ignored, then restarts.
  task automatic done_restart();
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk("done_high", 32'(Done), 32'd1);
      chk("done_cnt", 32'(InstrCnt), 32'(m_cnt));
      chk_strobes_zero("done");
      tick();
    end
    Stall = 1; Start = 1;
    tick();
    Stall = 0; Start = 0;
    @(negedge Clk);
    chk("done_stalled_start", 32'(Done), 32'd1);
    Start = 1;
    tick();
    Start = 0;
  endtask

  initial begin
    logic [IW-1:0] ins;
    // Reset, with Start held during reset to show reset wins.
    Reset = 1;
    tick();
    Start = 1;
    tick();
    Reset = 0; Start = 0;
    @(negedge Clk);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_cnt", 32'(InstrCnt), 32'd0);
    chk("rst_aluop", 32'(ALUOp), 32'd0);
    chk("rst_branch", 32'(Branch), 32'(1'b0));
    chk("rst_memtoreg", 32'(MemtoReg), 32'd0);
    chk("rst_alusrc", 32'(ALUSrc), 32'd0);
    chk_strobes_zero("rst");
    tick();
    @(negedge Clk);
    chk("idle_no_fetch", 32'(IRWrite), 32'd0);
    Start = 1;
    tick();
    Start = 0;

    run_instr(9'b00_010_0000, 1'b0, 1'b0, 0, 0, 0, 0);
    run_instr(9'b10_000_0000, 1'b0, 1'b0, 0, 0, 0, 0);
    run_instr(9'b10_001_0000, 1'b0, 1'b0, 0, 0, 0, 0);
    run_instr(9'b01_00_00000, 1'b1, 1'b0, 0, 0, 0, 0);
    run_instr(9'b01_00_00000, 1'b0, 1'b0, 0, 0, 0, 0);
    run_instr(9'b11_1_000000, 1'b0, 1'b0, 0, 0, 0, 0);
    run_instr(9'b00_010_0000, 1'b0, 1'b0, 3, 2, 0, 0);
    chk("stall_total_cycles", 32'(n_cyc), 32'd5);
    run_instr(9'h1FF, 1'b0, 1'b0, 0, 0, 0, 0);
    done_restart();

    for (int i = 0; i < 60; i++) begin
      ins = IW'($urandom);
      if ($urandom_range(0, 15) == 0) ins = '1;
      run_instr(ins, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0, 1, 1);
      if (&ins) done_restart();
    end

    // Reset during the last MEM cycle of a load aborts it without strobes.
    Instr = 9'b10_000_0000;
    for (int i = 0; i < 4; i++) tick();
    @(negedge Clk);
    chk("pre_rst_memtoreg", 32'(MemtoReg), 32'd1);
    Reset = 1;
    #1;
    chk("rst_mid_rw", 32'(RegWrite), 32'd0);
    chk("rst_mid_pcw", 32'(PCWrite), 32'd0);
    tick();
    Reset = 0;
    m_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      chk_strobes_zero("post_rst");
      chk("post_rst_memtoreg", 32'(MemtoReg), 32'd0);
      chk("post_rst_done", 32'(Done), 32'd0);
      chk("post_rst_cnt", 32'(InstrCnt), 32'(m_cnt));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm.md
Name: ctrl_fsm

Overview:
Multi-cycle control sequencer for the 9-bit processor and its wider variants. It fetches each instruction, decodes it, and drives registered datapath controls through FETCH/DECODE/EXEC/MEM phases. It resolves conditional branches from ALU flags, inserts parametrised memory wait states, halts on the HALT encoding, supports a stall input, and counts retired instructions. It sits between instruction memory/IR and the register file, ALU, data memory and PC.

Parameters:
IW, 9, instruction width (>=6); Type=Instr[IW-1:IW-2], SubOp=Instr[IW-3:IW-5]
OPW, 3, ALUOp width (>=3); narrower op fields are zero-extended
MEM_LAT, 2, data-memory cycles per load/store (>=1)
CNTW, 16, retired-instruction counter width

Ports:
Clk  in  1  clock
Reset  in  1  synchronous, active-high reset
Start  in  1  begin execution (sampled in IDLE/DONE only)
Stall  in  1  freeze FSM and suppress strobes this cycle
Instr  in  IW  instruction from instruction memory
Zero  in  1  ALU zero flag, sampled in EXEC
Neg  in  1  ALU negative flag, sampled in EXEC
IRWrite  out  1  latch instruction register
PCWrite  out  1  one-cycle PC update strobe
PCSrc  out  1  1: PC<=target, 0: PC+1 (valid with PCWrite)
RegDst  out  1  always 0
Branch  out  1  instruction is branch/jump
MemtoReg  out  1  write-back from memory
MemWrite  out  1  data-memory write strobe
ALUSrc  out  1  1: immediate, 0: register
RegWrite  out  1  register-file write strobe
ALUOp  out  OPW  ALU operation
Done  out  1  halted
InstrCnt  out  CNTW  retired instructions, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; InstrCnt 0. Reset mid-instruction aborts it with no further strobes. Reset beats Stall and Start.
- States: IDLE -Start-> FETCH -> DECODE -> EXEC -> (mem op ? MEM : FETCH). MEM stays MEM_LAT cycles, then -> FETCH. DECODE of HALT -> DONE. DONE -Start-> FETCH.
- Stall=1: state, counters and held controls freeze. IRWrite, PCWrite, RegWrite and MemWrite are 0 that cycle. The strobe fires on the first unstalled cycle.
- IRWrite=1 in FETCH only.
- Decode at DECODE. Controls are registered and held from EXEC to the end of the instruction:
  - Type 00, math: ALUOp=SubOp; RegWrite.
  - Type 01, cond: C=Instr[IW-3:IW-4]. ALUOp=ALU_SUB, Branch=1, no RegWrite. Taken: C 00 Zero; 01 !Zero; 10 Neg; 11 !Neg.
  - Type 10, assign: SubOp 000 load (MemtoReg, RegWrite); 001 store (MemWrite); else ALUOp=ALU_PASS with RegWrite.
  - Type 11, values: Instr[IW-3]=0 mov (ALUSrc=1, ALUOp=ALU_PASS, RegWrite); =1 jmp (Branch=1, always taken).
  - HALT = Instr all ones; takes priority over jmp.
- Strobes, one cycle per instruction:
  - Non-memory: RegWrite and PCWrite in EXEC.
  - Store: MemWrite in the first MEM cycle.
  - Load: RegWrite in the last MEM cycle.
  - Memory ops: PCWrite in the last MEM cycle.
  - PCSrc=1 with PCWrite iff a branch is taken or a jmp executes; otherwise 0.
- Latency: non-memory instruction 3 cycles; load/store 3+MEM_LAT cycles (unstalled).
- InstrCnt: +1 on each PCWrite; saturates at all ones. HALT is not counted.
- DONE: Done=1 held, all strobes 0. Start clears Done and goes to FETCH; InstrCnt is preserved.
- Start outside IDLE/DONE is ignored.

Decomposition:
- Package ctrl_pkg:
  - type_e: MATH, COND, ASSIGN, VALUES
  - state_e: IDLE, FETCH, DECODE, EXEC, MEM, DONE
  - ALU_SUB=3'b001, ALU_PASS=3'b111
  - ctrl_s struct of held controls
- One sub-module, ctrl_decode: combinational Instr -> ctrl_s plus is_mem, is_halt, cond code.
- ctrl_fsm owns state, wait counter, strobes, branch resolution and InstrCnt.

Test Plan:
- Reset, Start, Instr=9'b00_010_0000 -> IRWrite cycle 1, ALUOp=010 from EXEC; RegWrite=PCWrite=1 at cycle 3 only; PCSrc=0; InstrCnt=1.
- Load 9'b10_000_0000, MEM_LAT=2 -> MemtoReg=1 held from cycle 3; RegWrite and PCWrite only at cycle 5.
- Store 9'b10_001_0000 -> MemWrite at cycle 4 only; RegWrite never.
- Beq 9'b01_00_00000: Zero=1 -> PCWrite=PCSrc=1 at cycle 3. Repeat with Zero=0 -> PCSrc=0. Jmp 9'b11_1_000000 -> PCSrc=1.
- Stall=1 for 2 cycles during EXEC of math op -> no strobes while stalled; RegWrite/PCWrite on the first unstalled cycle; total 5 cycles.
- Instr=9'h1FF -> Done=1 after DECODE with no strobes and InstrCnt unchanged. Start -> Done=0 and FETCH. Reset during a load's MEM -> all outputs 0 and IDLE next cycle, no RegWrite.
